// File: rtl/pwr_off_ctl.sv
// Power-down sequencer for the USB display panel.
// Drops the backlight, sends DISPOFF/SLPIN to the command serializer, forces
// panel reset, then removes VCI and IOVCC with timed gaps. The *_allow outputs
// are masks that the top level ANDs with the power-on controller's enables.
module pwr_off_ctl #(
  parameter int CLK_FREQ       = 12000000,
  parameter int DLY_RAIL_MS    = 10,
  parameter int DLY_DISPOFF_MS = 20,
  parameter int DLY_SLPIN_MS   = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       off_req,
  input  logic       pwr_on_done,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       cmd_dc,
  output logic       bl_allow,
  output logic       panel_rst_allow,
  output logic       vci_allow,
  output logic       iovcc_allow,
  output logic       busy,
  output logic       off_done
);

  localparam int MS_CYC      = CLK_FREQ / 1000;
  localparam int RAIL_CYC    = DLY_RAIL_MS * MS_CYC;
  localparam int DISPOFF_CYC = DLY_DISPOFF_MS * MS_CYC;
  localparam int SLPIN_CYC   = DLY_SLPIN_MS * MS_CYC;
  localparam int MAX_CYC_A   = (RAIL_CYC > DISPOFF_CYC) ? RAIL_CYC : DISPOFF_CYC;
  localparam int MAX_CYC     = (MAX_CYC_A > SLPIN_CYC) ? MAX_CYC_A : SLPIN_CYC;
  localparam int CNT_W       = $clog2(MAX_CYC + 1);

  // Terminal counts: a wait of N cycles leaves the state when the counter,
  // cleared on entry, has reached N-1 at the leaving edge.
  localparam logic [CNT_W-1:0] RAIL_END    = CNT_W'(RAIL_CYC - 1);
  localparam logic [CNT_W-1:0] DISPOFF_END = CNT_W'(DISPOFF_CYC - 1);
  localparam logic [CNT_W-1:0] SLPIN_END   = CNT_W'(SLPIN_CYC - 1);

  localparam logic [7:0] CMD_DISPOFF_B = 8'h28;
  localparam logic [7:0] CMD_SLPIN_B   = 8'h10;

  typedef enum logic [3:0] {
    S_IDLE, S_BL_OFF, S_CMD_DISPOFF, S_WAIT_DISPOFF, S_CMD_SLPIN,
    S_WAIT_SLPIN, S_RST_ON, S_VCI_OFF, S_IOVCC_OFF, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_end;
  logic             w_is_wait;
  logic             w_cnt_hit;
  logic             w_xfer;

  logic             r_cmd_valid;
  logic [7:0]       r_cmd_data;
  logic             r_bl_allow;
  logic             r_panel_rst_allow;
  logic             r_vci_allow;
  logic             r_iovcc_allow;
  logic             r_busy;
  logic             r_off_done;

  logic             w_cmd_valid_nxt;
  logic [7:0]       w_cmd_data_nxt;
  logic             w_bl_allow_nxt;
  logic             w_panel_rst_allow_nxt;
  logic             w_vci_allow_nxt;
  logic             w_iovcc_allow_nxt;
  logic             w_busy_nxt;
  logic             w_off_done_nxt;

  assign w_xfer    = r_cmd_valid & cmd_ready;
  assign w_cnt_hit = (r_cnt == w_cnt_end);

  // Select the terminal count for the timed states.
  always_comb begin
    w_is_wait = 1'b1;
    w_cnt_end = RAIL_END;
    case (r_state)
      S_BL_OFF, S_RST_ON, S_VCI_OFF, S_IOVCC_OFF: w_cnt_end = RAIL_END;
      S_WAIT_DISPOFF:                             w_cnt_end = DISPOFF_END;
      S_WAIT_SLPIN:                               w_cnt_end = SLPIN_END;
      default:                                    w_is_wait = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; an uninitialised panel skips straight to reset assertion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:         if (off_req) w_state_nxt = pwr_on_done ? S_BL_OFF : S_RST_ON;
      S_BL_OFF:       if (w_cnt_hit) w_state_nxt = S_CMD_DISPOFF;
      S_CMD_DISPOFF:  if (w_xfer) w_state_nxt = S_WAIT_DISPOFF;
      S_WAIT_DISPOFF: if (w_cnt_hit) w_state_nxt = S_CMD_SLPIN;
      S_CMD_SLPIN:    if (w_xfer) w_state_nxt = S_WAIT_SLPIN;
      S_WAIT_SLPIN:   if (w_cnt_hit) w_state_nxt = S_RST_ON;
      S_RST_ON:       if (w_cnt_hit) w_state_nxt = S_VCI_OFF;
      S_VCI_OFF:      if (w_cnt_hit) w_state_nxt = S_IOVCC_OFF;
      S_IOVCC_OFF:    if (w_cnt_hit) w_state_nxt = S_DONE;
      S_DONE:         w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Delay counter: cleared on every state change, counts only in timed states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (w_state_nxt != r_state) r_cnt <= '0;
    else if (w_is_wait)             r_cnt <= r_cnt + 1'b1;
    else                            r_cnt <= '0;
  end

  // Output decode from the current state; masks only ever fall as the
  // sequence advances. cmd_valid drops on the accepting edge so each byte
  // is offered exactly once.
  always_comb begin
    w_bl_allow_nxt        = (r_state == S_IDLE);
    w_panel_rst_allow_nxt = (r_state == S_IDLE) || (r_state == S_BL_OFF) ||
                            (r_state == S_CMD_DISPOFF) || (r_state == S_WAIT_DISPOFF) ||
                            (r_state == S_CMD_SLPIN) || (r_state == S_WAIT_SLPIN);
    w_vci_allow_nxt       = w_panel_rst_allow_nxt || (r_state == S_RST_ON);
    w_iovcc_allow_nxt     = w_vci_allow_nxt || (r_state == S_VCI_OFF);
    w_busy_nxt            = (r_state != S_IDLE) && (r_state != S_DONE);
    w_off_done_nxt        = (r_state == S_DONE);
    w_cmd_valid_nxt       = ((r_state == S_CMD_DISPOFF) || (r_state == S_CMD_SLPIN)) && !w_xfer;
    w_cmd_data_nxt        = 8'h00;
    if (w_cmd_valid_nxt)
      w_cmd_data_nxt = (r_state == S_CMD_DISPOFF) ? CMD_DISPOFF_B : CMD_SLPIN_B;
  end

  // Registered outputs; reset restores all masks to permissive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_valid       <= 1'b0;
      r_cmd_data        <= 8'h00;
      r_bl_allow        <= 1'b1;
      r_panel_rst_allow <= 1'b1;
      r_vci_allow       <= 1'b1;
      r_iovcc_allow     <= 1'b1;
      r_busy            <= 1'b0;
      r_off_done        <= 1'b0;
    end else begin
      r_cmd_valid       <= w_cmd_valid_nxt;
      r_cmd_data        <= w_cmd_data_nxt;
      r_bl_allow        <= w_bl_allow_nxt;
      r_panel_rst_allow <= w_panel_rst_allow_nxt;
      r_vci_allow       <= w_vci_allow_nxt;
      r_iovcc_allow     <= w_iovcc_allow_nxt;
      r_busy            <= w_busy_nxt;
      r_off_done        <= w_off_done_nxt;
    end
  end

  assign cmd_valid       = r_cmd_valid;
  assign cmd_data        = r_cmd_data;
  assign cmd_dc          = 1'b0;
  assign bl_allow        = r_bl_allow;
  assign panel_rst_allow = r_panel_rst_allow;
  assign vci_allow       = r_vci_allow;
  assign iovcc_allow     = r_iovcc_allow;
  assign busy            = r_busy;
  assign off_done        = r_off_done;

endmodule

// File: tb/tb_pwr_off_ctl.sv
// Directed bench for pwr_off_ctl with a 1 ms = 120 cycle clock.
module tb_pwr_off_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       off_req = 1'b0;
  logic       pwr_on_done = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_dc;
  logic       bl_allow;
  logic       panel_rst_allow;
  logic       vci_allow;
  logic       iovcc_allow;
  logic       busy;
  logic       off_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit vseen  = 1'b0;

  pwr_off_ctl #(
    .CLK_FREQ(120000), .DLY_RAIL_MS(10), .DLY_DISPOFF_MS(20), .DLY_SLPIN_MS(120)
  ) dut (
    .clk(clk), .reset(reset), .off_req(off_req), .pwr_on_done(pwr_on_done),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_dc(cmd_dc), .bl_allow(bl_allow), .panel_rst_allow(panel_rst_allow),
    .vci_allow(vci_allow), .iovcc_allow(iovcc_allow), .busy(busy),
    .off_done(off_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_valid === 1'b1) vseen = 1'b1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_allows(input string tag, input logic [3:0] exp);
    chk(tag, {4'b0, bl_allow, panel_rst_allow, vci_allow, iovcc_allow}, {4'b0, exp});
  endtask

  // Full initialised power-down. E0 is the first edge that sees off_req=1.
  // stall: cycles cmd_ready is held low while DISPOFF is offered.
  // drop: release off_req once WAIT_SLPIN has started.
  task automatic full_seq(input int stall, input bit drop);
    pwr_on_done = 1'b1;
    off_req     = 1'b1;
    cmd_ready   = (stall == 0);
    step(1);                                   // E0
    chk("f_bl_e0", bl_allow, 1'b1);
    chk("f_busy_e0", busy, 1'b0);
    step(1);                                   // E0+1
    chk("f_bl_e1", bl_allow, 1'b0);
    chk("f_busy_e1", busy, 1'b1);
    chk("f_prst_e1", panel_rst_allow, 1'b1);
    step(1199);                                // E0+1200
    chk("f_v28_pre", cmd_valid, 1'b0);
    step(1);                                   // E0+1201
    chk("f_v28", cmd_valid, 1'b1);
    chk("f_d28", cmd_data, 8'h28);
    chk("f_dc", cmd_dc, 1'b0);
    if (stall > 0) begin
      step(stall / 2);
      chk("f_stall_v", cmd_valid, 1'b1);
      chk("f_stall_d", cmd_data, 8'h28);
      step(stall - stall / 2);
      chk("f_stall_v2", cmd_valid, 1'b1);
      chk("f_stall_d2", cmd_data, 8'h28);
      cmd_ready = 1'b1;
    end
    step(1);                                   // E0+1202+s
    chk("f_v28_post", cmd_valid, 1'b0);
    step(2400);                                // E0+3602+s
    chk("f_v10_pre", cmd_valid, 1'b0);
    step(1);
    chk("f_v10", cmd_valid, 1'b1);
    chk("f_d10", cmd_data, 8'h10);
    step(1);                                   // E0+3604+s, WAIT_SLPIN
    chk("f_v10_post", cmd_valid, 1'b0);
    if (drop) off_req = 1'b0;
    step(14400);                               // E0+18004+s
    chk("f_prst_pre", panel_rst_allow, 1'b1);
    step(1);
    chk_allows("f_prst", 4'b0011);
    step(1199);
    chk("f_vci_pre", vci_allow, 1'b1);
    step(1);
    chk_allows("f_vci", 4'b0001);
    step(1199);
    chk("f_io_pre", iovcc_allow, 1'b1);
    step(1);
    chk_allows("f_io", 4'b0000);
    chk("f_busy_io", busy, 1'b1);
    step(1199);
    chk("f_done_pre", off_done, 1'b0);
    step(1);
    chk("f_done", off_done, 1'b1);
    chk("f_busy_done", busy, 1'b0);
    chk_allows("f_done_allows", 4'b0000);
    chk("f_v_done", cmd_valid, 1'b0);
  endtask

  initial begin
    // Reset state
    step(2);
    chk_allows("rst_allows", 4'b1111);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_data", cmd_data, 8'h00);
    chk("rst_dc", cmd_dc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", off_done, 1'b0);
    reset = 1'b1;
    step(3);
    chk("idle_busy", busy, 1'b0);
    chk_allows("idle_allows", 4'b1111);

    // Plain full sequence
    full_seq(0, 1'b0);

    // DONE is sticky regardless of inputs
    for (int i = 0; i < 6; i++) begin
      off_req     = i[0];
      pwr_on_done = i[1];
      step(1);
    end
    chk("done_sticky", off_done, 1'b1);
    chk_allows("done_sticky_allows", 4'b0000);
    chk("done_sticky_busy", busy, 1'b0);

    // Uninitialised panel: no commands, go straight to reset assertion
    reset = 1'b0; off_req = 1'b0; pwr_on_done = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    vseen = 1'b0;
    off_req = 1'b1;
    step(1);
    chk("n_bl_e0", bl_allow, 1'b1);
    step(1);
    chk_allows("n_e1", 4'b0011);
    step(1199);
    chk("n_vci_pre", vci_allow, 1'b1);
    step(1);
    chk_allows("n_vci", 4'b0001);
    step(1199);
    chk("n_io_pre", iovcc_allow, 1'b1);
    step(1);
    chk_allows("n_io", 4'b0000);
    step(1199);
    chk("n_done_pre", off_done, 1'b0);
    step(1);
    chk("n_done", off_done, 1'b1);
    chk("n_no_cmd", vseen, 1'b0);

    // Stall on DISPOFF plus off_req dropped during WAIT_SLPIN
    reset = 1'b0; off_req = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    full_seq(500, 1'b1);

    // Reset asserted during WAIT_SLPIN, then a fresh full sequence
    reset = 1'b0; off_req = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    pwr_on_done = 1'b1; off_req = 1'b1; cmd_ready = 1'b1;
    step(4000);
    chk("m_busy", busy, 1'b1);
    chk_allows("m_allows", 4'b0111);
    reset = 1'b0;
    #1;
    chk_allows("m_rst_allows", 4'b1111);
    chk("m_rst_busy", busy, 1'b0);
    chk("m_rst_done", off_done, 1'b0);
    chk("m_rst_valid", cmd_valid, 1'b0);
    off_req = 1'b0;
    step(3);
    reset = 1'b1;
    step(10);
    chk("m_idle_busy", busy, 1'b0);
    chk_allows("m_idle_allows", 4'b1111);
    full_seq(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwr_off_ctl.md
Name: pwr_off_ctl

Overview:
- Power-down sequencer for the USB display panel. It is the counterpart of the power-on controller.
- On a shutdown request it:
  - drops the backlight,
  - sends DISPOFF (0x28) then SLPIN (0x10) to the panel command serializer,
  - asserts panel reset,
  - removes VCI, then IOVCC, in reverse power-up order with timed gaps.
- Outputs are "allow" masks. At top level they are ANDed with the power-on controller's enables.

Parameters:
- CLK_FREQ, 12000000: clock frequency in Hz. One ms = CLK_FREQ/1000 cycles (integer division).
- DLY_RAIL_MS, 10: gap after each rail/backlight/reset step.
- DLY_DISPOFF_MS, 20: wait after DISPOFF accepted.
- DLY_SLPIN_MS, 120: wait after SLPIN accepted.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- off_req  input  1  shutdown request level, sampled in IDLE.
- pwr_on_done  input  1  power-on controller finished panel init.
- cmd_ready  input  1  serializer can accept a byte.
- cmd_valid  output  1  command byte valid.
- cmd_data  output  8  command byte.
- cmd_dc  output  1  data/command select, always 0 (command).
- bl_allow  output  1  backlight permitted.
- panel_rst_allow  output  1  1 = panel reset released permitted; 0 forces panel reset.
- vci_allow  output  1  VCI rail permitted.
- iovcc_allow  output  1  IOVCC rail permitted.
- busy  output  1  sequence in progress.
- off_done  output  1  sequence complete (sticky).

Behaviour:
- Reset values (reset=0, immediate, asynchronous):
  - state=IDLE.
  - all *_allow = 1.
  - cmd_valid = 0, cmd_data = 0x00, cmd_dc = 0.
  - busy = 0, off_done = 0.
  - delay counter = 0.
- States: IDLE, BL_OFF, CMD_DISPOFF, WAIT_DISPOFF, CMD_SLPIN, WAIT_SLPIN, RST_ON, VCI_OFF, IOVCC_OFF, DONE.
- IDLE:
  - off_req=1 and pwr_on_done=1 -> BL_OFF.
  - off_req=1 and pwr_on_done=0 -> RST_ON. Panel is not initialised, so no commands are sent and BL_OFF is skipped; bl_allow is still cleared in the same cycle.
- busy=1 in every state except IDLE and DONE. Output changes are registered: they appear the cycle after the state transition.
- BL_OFF:
  - bl_allow=0.
  - Wait DLY_RAIL_MS*ms cycles -> CMD_DISPOFF.
- CMD_DISPOFF:
  - cmd_valid=1, cmd_data=0x28.
  - Byte held stable until a rising edge with cmd_valid=1 and cmd_ready=1.
  - Then cmd_valid=0 the next cycle -> WAIT_DISPOFF.
  - cmd_ready held low stalls indefinitely (no timeout).
- WAIT_DISPOFF: wait DLY_DISPOFF_MS*ms cycles -> CMD_SLPIN.
- CMD_SLPIN: same handshake with 0x10 -> WAIT_SLPIN.
- WAIT_SLPIN: wait DLY_SLPIN_MS*ms cycles -> RST_ON.
- RST_ON:
  - panel_rst_allow=0.
  - Wait DLY_RAIL_MS*ms -> VCI_OFF.
- VCI_OFF:
  - vci_allow=0.
  - Wait DLY_RAIL_MS*ms -> IOVCC_OFF.
- IOVCC_OFF:
  - iovcc_allow=0.
  - Wait DLY_RAIL_MS*ms -> DONE.
- DONE:
  - off_done=1, busy=0, all allows 0.
  - Sticky until reset; off_req and pwr_on_done are ignored.
- Delay counter:
  - Width = $clog2(max delay in cycles + 1).
  - Cleared on every state entry.
  - A wait of N cycles means the state is left on the Nth cycle after entry.
  - No wrap: the counter is compared with `==` and never exceeds N.
- off_req deasserting mid-sequence has no effect; the sequence always completes.
- pwr_on_done changes after leaving IDLE are ignored.
- cmd_ready is ignored when cmd_valid=0.
- Reset asserted mid-sequence (including during a handshake) immediately restores all allows to 1 and drops cmd_valid. The top level also resets the power-on controller so that the rails re-sequence cleanly.

Test Plan (CLK_FREQ=120000, so 1 ms = 120 cycles):
- Reset, then off_req=1 with pwr_on_done=1 and cmd_ready=1 -> required timing:
  - bl_allow=0 at +1 cycle.
  - cmd_valid/0x28 after 1200 cycles, held 1 cycle.
  - 0x10 after a further 2400.
  - panel_rst_allow=0 after a further 14400.
  - vci_allow=0 and iovcc_allow=0 each 1200 apart.
  - off_done=1 1200 cycles after IOVCC_OFF entry; busy=0.
- Hold cmd_ready=0 for 500 cycles during CMD_DISPOFF -> cmd_valid stays 1 with cmd_data=0x28 stable. The byte transfers on the first edge with cmd_ready=1, then WAIT_DISPOFF begins.
- off_req=1 with pwr_on_done=0 -> no cmd_valid ever. bl_allow and panel_rst_allow drop at +1, then vci_allow at +1200, iovcc_allow at +2400, off_done at +3600.
- Drop off_req to 0 during WAIT_SLPIN -> sequence continues and reaches DONE with identical timing.
- Assert reset (0) for 3 cycles during WAIT_SLPIN, then release -> all allows=1, busy=0, off_done=0 immediately. Block idles until off_req, then performs a full sequence.
- In DONE, toggle off_req and pwr_on_done -> off_done stays 1 and all allows stay 0.
